fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Instruction-fetch front end for the 5-stage MIPS pipeline: sequences the fetch PC,
//  issues requests to instruction memory (variable latency, in-order, one outstanding)
//  and buffers returned words in a DEPTH-entry FIFO feeding the IF/ID register.
//  Decouples decode stalls from fetch and flushes on branch redirect (beq taken).
// PARAMETERS
//  DEPTH     4       queue entries; power of two, >= 2
//  RESET_PC  32'h0   first fetch address after reset
// PORTS
//  clock        in   1   single clock; all state updates on posedge
//  reset        in   1   synchronous, active-high
//  imem_req     out  1   request strobe, one cycle per request
//  imem_addr    out  32  request address (valid when imem_req=1)
//  imem_valid   in   1   response strobe for the oldest outstanding request
//  imem_data    in   32  instruction word (valid when imem_valid=1)
//  redirect     in   1   branch taken: flush queue, refetch from redirect_pc
//  redirect_pc  in   32  new fetch address
//  inst_valid   out  1   head entry presented to decode
//  inst_ready   in   1   decode accepts head (0 = stall)
//  inst_out     out  32  head instruction; 32'b0 (nop) when inst_valid=0
//  pc_next_out  out  32  head PC + 4 (as consumed by IF/ID); 0 when inst_valid=0
//  count        out  $clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
//  State: fetch_pc, FIFO entries {instr, pc}, rd/wr pointers mod DEPTH, count,
//   pending (1 request in flight), drop (in-flight response is stale).
//  Reset (sync): fetch_pc=RESET_PC, count=0, pointers=0, pending=0, drop=0;
//   while reset=1: imem_req=0, inst_valid=0, inst_out=0, pc_next_out=0.
//   Reset mid-flight discards everything; later imem_valid ignored (pending=0).
//  pop  = inst_valid & inst_ready.
//  push = imem_valid & pending & ~drop & ~redirect; entry {imem_data, pc of that req}.
//  imem_valid with pending=0 is ignored.
//  Issue: imem_req = ~reset & ~redirect & (~pending | imem_valid)
//   & (count + pending - pop < DEPTH) -- slot reserved at issue, never overflows.
//   On issue: imem_addr=fetch_pc, pending<=1, fetch_pc<=fetch_pc+4 (wraps mod 2^32).
//   Back-to-back issue when response and next request coincide (1/cycle at 1-cycle mem).
//  Response with no new issue: pending<=0. Response with drop=1: discarded, drop<=0.
//  Redirect (priority over push/pop/issue): count<=0, pointers<=0,
//   fetch_pc<=redirect_pc, drop<=pending & ~imem_valid, pending<=pending & ~imem_valid;
//   inst_valid forced 0 combinationally that cycle (no pop). First request next cycle.
//  Output: inst_valid = (count!=0) & ~redirect & ~reset; combinational from head entry.
//  Simultaneous push+pop: count unchanged, pointers both advance (also at full/wrap).
//  Empty: inst_out=32'b0 so IF/ID sees a nop (all-zero controls).
//  Latency: with 1-cycle memory, request at cycle N -> inst_valid at cycle N+2.
// TESTING
//  1 RESET_PC=0, 1-cycle mem, inst_ready=1: imem_addr 0,4,8,12 on consecutive cycles;
//    decode sees pc_next_out 4,8,12,16 in order, first inst_valid 2 cycles after reset drop.
//  2 inst_ready=0, DEPTH=4: count reaches 4, imem_req stays 0; raise ready -> 4 words
//    drained in order, fetch resumes at 0x10 without gap or duplicate.
//  3 3-cycle mem, redirect to 0x40 one cycle after req to 0x8: stale 0x8 response
//    dropped, count=0, next imem_addr=0x40, first delivered pc_next_out=0x44.
//  4 Full queue, pop and response same cycle: count stays 4, no lost/overwritten entry;
//    run 3*DEPTH words to cover pointer wrap.
//  5 Empty queue (mem stalled): inst_valid=0, inst_out=32'h0, pc_next_out=0.
//  6 Assert reset with pending request and 2 entries: next cycle count=0, imem_addr
//    =RESET_PC after release; late imem_valid during/after reset produces no entry.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch front-end bus: instruction-memory port plus the decode-facing queue head.
// master = fetch_queue side, slave = memory/decode side.
interface fetch_queue_if #(parameter int DEPTH = 4);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              imem_req;
    logic [31:0]       imem_addr;
    logic              imem_valid;
    logic [31:0]       imem_data;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic [31:0]       inst_out;
    logic [31:0]       pc_next_out;
    logic [CW-1:0]     count;

    modport master (
        output imem_req, imem_addr,
        input  imem_valid, imem_data,
        input  redirect, redirect_pc,
        output inst_valid,
        input  inst_ready,
        output inst_out, pc_next_out, count
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_valid, imem_data,
        output redirect, redirect_pc,
        input  inst_valid,
        output inst_ready,
        input  inst_out, pc_next_out, count
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: sequences fetch PC, keeps one imem request in flight
// and buffers returned words in a DEPTH-entry FIFO ahead of the IF/ID register.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input logic           clock,
    input logic           reset,
    fetch_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t        entries [DEPTH];
    entry_t        head;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic [31:0]   fetch_pc, req_pc;
    logic          pending, drop;
    logic          inst_valid, pop, rsp, push, issue;
    logic [CW:0]   reserved;

    assign head = entries[rd_ptr];

    always_comb begin
        inst_valid = (count != '0) & ~bus.redirect & ~reset;
        pop        = inst_valid & bus.inst_ready;
        rsp        = bus.imem_valid & pending;
        push       = rsp & ~drop & ~bus.redirect;
        // The in-flight request already owns a slot, so the full check counts it.
        reserved   = {1'b0, count} + {{CW{1'b0}}, pending} - {{CW{1'b0}}, pop};
        issue      = ~reset & ~bus.redirect & (~pending | bus.imem_valid)
                   & (reserved < (CW+1)'(DEPTH));
    end

    assign bus.imem_req    = issue;
    assign bus.imem_addr   = fetch_pc;
    assign bus.inst_valid  = inst_valid;
    assign bus.inst_out    = inst_valid ? head.instr : 32'h0;
    assign bus.pc_next_out = inst_valid ? head.pc + 32'd4 : 32'h0;
    assign bus.count       = count;

    always_ff @(posedge clock) begin
        if (push) entries[wr_ptr] <= '{instr: bus.imem_data, pc: req_pc};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            pending  <= 1'b0;
            drop     <= 1'b0;
        end else if (bus.redirect) begin
            // A response landing this same cycle retires the old request outright.
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fetch_pc <= bus.redirect_pc;
            drop     <= pending & ~bus.imem_valid;
            pending  <= pending & ~bus.imem_valid;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push & ~pop)      count <= count + CW'(1);
            else if (pop & ~push) count <= count - CW'(1);
            if (rsp & drop) drop <= 1'b0;
            if (issue) begin
                pending  <= 1'b1;
                req_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + 32'd4;
            end else if (rsp) begin
                pending  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: random-latency memory and decode stalls against a queue-based
// model of delivered instructions, plus directed stall/redirect/reset scenarios.
module tb_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    fetch_queue_if #(.DEPTH(DEPTH)) bus ();
    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );

    typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;

    int checks = 0;
    int errors = 0;

    // Reference model: delivered stream as a queue, one-outstanding memory
    ent_t        q[$];
    bit          m_out, m_stale;
    logic [31:0] m_out_pc, mem_addr, m_fetch, m_seq;
    int          lat;
    // Stimulus knobs
    int lat_min, lat_max, rdy_pct, redir_pct, rst_pct, spur_pct;
    bit f_rst, f_redir;
    logic [31:0] f_redir_pc;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        bit rv, exp_v, mp, exp_req, r, rd;
        logic [31:0] rnd, dut_addr, rpc;
        @(negedge clock);
        r     = f_rst || ($urandom_range(999) < 10 * rst_pct);
        reset = r;
        rv    = m_out && (lat == 0);
        bus.imem_valid = rv || (!m_out && $urandom_range(99) < spur_pct);
        bus.imem_data  = rv ? word_of(mem_addr) : $urandom;
        rd = !r && (f_redir || $urandom_range(99) < redir_pct);
        rnd = $urandom;
        rpc = f_redir ? f_redir_pc : (rnd[1:0] == 2'b00 ? 32'hFFFF_FFF4 : rnd & 32'hFFFF_FFFC);
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.inst_ready  = $urandom_range(99) < rdy_pct;
        #1;
        exp_v   = q.size() != 0 && !rd && !r;
        mp      = exp_v && bus.inst_ready;
        exp_req = !r && !rd && (!m_out || rv) && (int'(q.size()) + int'(m_out) - int'(mp) < DEPTH);
        chk("inst_valid", 32'(bus.inst_valid), 32'(exp_v));
        chk("inst_out", bus.inst_out, exp_v ? q[0].instr : 32'h0);
        chk("pc_next_out", bus.pc_next_out, exp_v ? q[0].pc + 32'd4 : 32'h0);
        chk("count", 32'(bus.count), 32'(q.size()));
        chk("imem_req", 32'(bus.imem_req), 32'(exp_req));
        if (exp_req) chk("imem_addr", bus.imem_addr, m_fetch);
        if (mp) begin
            chk("deliver_order", bus.pc_next_out, m_seq + 32'd4);
            m_seq = m_seq + 32'd4;
        end
        dut_addr = bus.imem_addr;
        @(posedge clock);
        if (m_out && !rv && lat > 0) lat--;
        if (r) begin
            q.delete();
            m_out = 0; m_stale = 0;
            m_fetch = RESET_PC; m_seq = RESET_PC;
        end else if (rd) begin
            q.delete();
            m_stale = m_out && !rv;
            m_out   = m_out && !rv;
            m_fetch = rpc; m_seq = rpc;
        end else begin
            if (mp) void'(q.pop_front());
            if (rv) begin
                if (!m_stale) q.push_back('{instr: word_of(m_out_pc), pc: m_out_pc});
                m_out = 0; m_stale = 0;
            end
            if (exp_req) begin
                m_out = 1; m_stale = 0;
                m_out_pc = m_fetch; mem_addr = dut_addr;
                lat = $urandom_range(lat_max, lat_min);
                m_fetch = m_fetch + 32'd4;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic knobs(input int lmin, input int lmax, input int rdy,
                         input int redir, input int rst, input int spur);
        lat_min = lmin; lat_max = lmax; rdy_pct = rdy;
        redir_pct = redir; rst_pct = rst; spur_pct = spur;
    endtask

    initial begin
        int guard;
        m_out = 0; m_stale = 0; lat = 0;
        m_fetch = RESET_PC; m_seq = RESET_PC; m_out_pc = 0; mem_addr = 0;
        f_rst = 0; f_redir = 0; f_redir_pc = 0;
        bus.imem_valid = 0; bus.imem_data = 0; bus.redirect = 0;
        bus.redirect_pc = 0; bus.inst_ready = 0;
        repeat (2) @(posedge clock);

        // Reset state, then 1-cycle memory streaming with decode always ready
        f_rst = 1; knobs(0, 0, 100, 0, 0, 0); run(2); f_rst = 0;
        #2 chk("reset_count", 32'(bus.count), 32'h0);
        run(20);

        // Decode stall fills the queue and halts fetch; release drains in order
        knobs(0, 0, 0, 0, 0, 0); run(12);
        #2 chk("full_count", 32'(bus.count), DEPTH);
        chk("full_noreq", 32'(bus.imem_req), 32'h0);
        knobs(0, 0, 100, 0, 0, 0); run(12);

        // 3-cycle memory: redirect to 0x40 the cycle after the request to 0x8
        f_rst = 1; knobs(2, 2, 100, 0, 0, 0); run(2); f_rst = 0;
        guard = 0;
        while (!(m_out && m_out_pc == 32'h8) && guard < 40) begin cycle(); guard++; end
        chk("found_req8", 32'(guard < 40), 32'h1);
        f_redir = 1; f_redir_pc = 32'h40; cycle(); f_redir = 0;
        #2 chk("redir_count", 32'(bus.count), 32'h0);
        run(20);

        // Full queue with simultaneous pop and response, many wraps
        knobs(0, 0, 50, 0, 0, 0); run(200);

        // Slow memory: queue often empty, outputs must read as nop
        knobs(6, 6, 100, 0, 0, 0); run(40);

        // Reset with a request in flight and entries queued; late responses ignored
        knobs(3, 3, 0, 0, 0, 0); run(10);
        f_rst = 1; knobs(3, 3, 0, 0, 0, 60); cycle(); f_rst = 0;
        #2 chk("rst_mid_count", 32'(bus.count), 32'h0);
        run(10);
        knobs(0, 3, 100, 0, 0, 0); run(20);

        // Random mix of latency, stalls, redirects, resets and spurious strobes
        knobs(0, 3, 70, 5, 1, 10); run(3000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
